// File: rtl/dmem_lsu_if.sv
// Load/store unit bus bundle: datapath request/response channel plus the dmem port.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready toward the LSU, resp_valid/resp_ready back out of it.
// Ports:
//   req_*  : request from the memory stage (valid/ready, store flag, size, signedness, byte address, store data)
//   resp_* : response to the memory stage (valid/ready, load data, error flag)
//   mem_*  : single-port dmem (word address, write enable, write data, combinational read data)
// The slave modport is the LSU; master is everything around it (datapath and dmem).
interface dmem_lsu_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_lsu.sv
// Byte/half/word load-store unit over a word-only dmem; sub-word stores done as read-modify-write.
// Latency (accept edge to resp_valid): load 2, word store 2, sub-word store 3, error 1.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
// Ports:
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : dmem_lsu_if.slave carrying the request, response and dmem channels
module dmem_lsu #(
    parameter int AW = 32
) (
    input  logic         clk,
    input  logic         reset,
    dmem_lsu_if.slave    bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic          we_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   wd_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          req_err;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [31:0]   load_val;
    logic [31:0]   merged;

    // Illegal size, or an access that is not naturally aligned.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Little-endian lane select on the word currently read, plus extension for loads
    // and lane merge for sub-word stores (other lanes keep their memory value).
    always_comb begin
        lane8 = 8'h00;
        case (addr_q[1:0])
            2'd0: lane8 = bus.mem_rd[7:0];
            2'd1: lane8 = bus.mem_rd[15:8];
            2'd2: lane8 = bus.mem_rd[23:16];
            2'd3: lane8 = bus.mem_rd[31:24];
            default: lane8 = 8'h00;
        endcase
        lane16 = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

        load_val = bus.mem_rd;
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{lane8[7]}}, lane8} : {24'h0, lane8};
            2'b01:   load_val = signed_q ? {{16{lane16[15]}}, lane16} : {16'h0, lane16};
            default: load_val = bus.mem_rd;
        endcase

        merged = bus.mem_rd;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = bus.mem_rd;
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            wd_q     <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        wd_q     <= 32'h0;
                        rdata_q  <= 32'h0;
                        err_q    <= req_err;
                        if (req_err)
                            state <= RESP;
                        else if (bus.req_we && bus.req_size == 2'b10)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (we_q) begin
                        wd_q  <= merged;
                        state <= WRITE;
                    end else begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (bus.resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Gated by reset as well so the write strobe drops the instant reset rises,
    // independent of how the state register reset is ordered in simulation.
    assign bus.mem_we = (state == WRITE) && !reset;
    assign bus.mem_a  = {addr_q[AW-1:2], 2'b00};
    // Word stores write the request data directly; sub-word stores write the merged word.
    assign bus.mem_wd = (size_q == 2'b10) ? wdata_q : wd_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_lsu_if #(.AW(AW)) bus();
    dmem_lsu #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // 64x32 dmem: combinational read, posedge write; a backdoor port for preloading.
    logic [31:0] mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_dat = 32'h0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          we_cyc = -1;
    logic [31:0] we_wd = 32'h0;

    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    always @(posedge clk) begin
        cyc++;
        if (bus.mem_we) begin
            mem[bus.mem_a[7:2]] <= bus.mem_wd;
            we_cnt++;
            we_cyc = cyc;
            we_wd  = bus.mem_wd;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_dat;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int failed = 0;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    int          accept_cyc;
    logic [31:0] mdl [0:63];

    task automatic bd_write(input int idx, input logic [31:0] dat);
        bd_idx = idx[5:0];
        bd_dat = dat;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we  = 1'b0;
    endtask

    // Drives one request, records the expectation, collects the response
    // (latency counted in edges from the accept edge) and completes the handshake.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] e_rd, input logic e_err, input int e_lat);
        exp_t e;
        int w;
        e.rdata = e_rd; e.err = e_err; e.lat = e_lat;
        sb.push_back(e);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
        got_lat = -1; got_rdata = 'x; got_err = 'x;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        accept_cyc = cyc;
        bus.req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (bus.resp_valid) begin
                got_lat = n; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] a);
        logic [31:0] s = w >> (8 * a);
        if (sz == 2'b00) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        if (sz == 2'b01) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] w, logic [1:0] sz, logic [1:0] a, logic [31:0] d);
        logic [31:0] m = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (w & ~(m << (8 * a))) | ((d & m) << (8 * a));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we} !== 4'b1000) begin
            failed++;
            $display("FAIL reset_ctrl got rdy/vld/err/we=%b want 1000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we});
        end
        tests++;
        if ({bus.resp_rdata, bus.mem_a, bus.mem_wd} !== 96'h0) begin
            failed++;
            $display("FAIL reset_data got rdata=%h a=%h wd=%h want all 0",
                     bus.resp_rdata, bus.mem_a, bus.mem_wd);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < 64; i++) bd_write(i, $urandom);
    endtask

    task automatic test_word();
        exp_t e;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        e = sb.pop_front();
        tests++;
        if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat) begin
            failed++;
            $display("FAIL word_store got %h/%b/lat%0d want %h/%b/lat%0d", got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        e = sb.pop_front();
        tests++;
        if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat) begin
            failed++;
            $display("FAIL word_load got %h/%b/lat%0d want %h/%b/lat%0d", got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
        end
        tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL word_mem got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic test_byte_store();
        exp_t e;
        int we0;
        bd_write(4, 32'h11223344);
        we0 = we_cnt;
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAA, 32'h0, 1'b0, 3);
        e = sb.pop_front();
        tests++;
        if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat) begin
            failed++;
            $display("FAIL byte_store_resp got %h/%b/lat%0d want %h/%b/lat%0d", got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
        end
        tests++;
        if (we_cnt - we0 != 1 || we_cyc != accept_cyc + 2 || we_wd !== 32'h1122AA44) begin
            failed++;
            $display("FAIL byte_store_we got pulses=%0d at+%0d wd=%h want 1 at+2 wd=1122aa44",
                     we_cnt - we0, we_cyc - accept_cyc, we_wd);
        end
        tests++;
        if (mem[4] !== 32'h1122AA44) begin
            failed++;
            $display("FAIL byte_store_mem got %h want 1122aa44", mem[4]);
        end
    endtask

    task automatic test_extend();
        logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        logic        sg  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad  [8] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10, 32'h11, 32'h13, 32'h12};
        logic [31:0] ex  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                 32'h00007F80, 32'h0000007F, 32'hFFFFFF80, 32'h00000001};
        exp_t e;
        bd_write(4, 32'h8001_7F80);
        for (int i = 0; i < 8; i++) begin
            run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, ex[i], 1'b0, 2);
            e = sb.pop_front();
            tests++;
            if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat) begin
                failed++;
                $display("FAIL extend_%0d got %h/%b/lat%0d want %h/%b/lat%0d", i, got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
            end
        end
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3);
        e = sb.pop_front();
        tests++;
        if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat || mem[4] !== 32'h12347F80) begin
            failed++;
            $display("FAIL half_store got %h/%b/lat%0d mem=%h want 0/0/lat3 mem=12347f80", got_rdata, got_err, got_lat, mem[4]);
        end
    endtask

    task automatic test_errors();
        logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
        logic [31:0] ad [5] = '{32'h06, 32'h11, 32'h10, 32'h12, 32'h13};
        logic [31:0] m1, m4;
        int we0;
        exp_t e;
        m1 = mem[1]; m4 = mem[4]; we0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            run_req(we[i], sz[i], 1'b1, ad[i], 32'hA5A5_A5A5, 32'h0, 1'b1, 1);
            e = sb.pop_front();
            tests++;
            if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat) begin
                failed++;
                $display("FAIL error_%0d got %h/%b/lat%0d want %h/%b/lat%0d", i, got_rdata, got_err, got_lat, e.rdata, e.err, e.lat);
            end
        end
        tests++;
        if (we_cnt != we0 || mem[1] !== m1 || mem[4] !== m4) begin
            failed++;
            $display("FAIL error_nowrite got pulses=%0d m1=%h m4=%h want 0 %h %h", we_cnt - we0, mem[1], mem[4], m1, m4);
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        int n;
        bd_write(6, 32'hCAFEF00D);
        bd_write(7, 32'h0BADC0DE);
        e1.rdata = 32'hCAFEF00D; e1.err = 1'b0; e1.lat = 2; sb.push_back(e1);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h18;
        @(posedge clk); #1;
        e2.rdata = 32'h0BADC0DE; e2.err = 1'b0; e2.lat = 2; sb.push_back(e2);
        bus.req_addr = 32'h1C;
        n = 1;
        while (!bus.resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        e1 = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e1.rdata || bus.req_ready !== 1'b0 || n != e1.lat) begin
                failed++;
                $display("FAIL hold_%0d got vld=%b rdata=%h rdy=%b lat%0d want 1 %h 0 lat%0d",
                         i, bus.resp_valid, bus.resp_rdata, bus.req_ready, n, e1.rdata, e1.lat);
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failed++;
            $display("FAIL after_handshake got rdy=%b vld=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        e2 = sb.pop_front();
        tests++;
        if (bus.resp_rdata !== e2.rdata || n != e2.lat) begin
            failed++;
            $display("FAIL held_req got %h lat%0d want %h lat%0d", bus.resp_rdata, n, e2.rdata, e2.lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        int we0;
        bd_write(4, 32'h11223344);
        we0 = we_cnt;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus.mem_we !== 1'b1) begin
            failed++;
            $display("FAIL rst_pre_we got %b want 1", bus.mem_we);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.mem_we, bus.req_ready, bus.resp_valid, bus.resp_err} !== 4'b0100 ||
            {bus.resp_rdata, bus.mem_a, bus.mem_wd} !== 96'h0) begin
            failed++;
            $display("FAIL rst_async got we/rdy/vld/err=%b rdata=%h a=%h wd=%h want 0100 and zeros",
                     {bus.mem_we, bus.req_ready, bus.resp_valid, bus.resp_err}, bus.resp_rdata, bus.mem_a, bus.mem_wd);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_idle_check(we0);
    endtask

    task automatic n_idle_check(input int we0);
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        tests++;
        if (mem[4] !== 32'h11223344 || we_cnt != we0 || bus.req_ready !== 1'b1 || seen != 0) begin
            failed++;
            $display("FAIL rst_after got mem=%h pulses=%0d rdy=%b resp_seen=%0d want 11223344 0 1 0",
                     mem[4], we_cnt - we0, bus.req_ready, seen);
        end
    endtask

    task automatic test_back_to_back();
        logic        we, sg;
        logic [1:0]  sz, off;
        logic [31:0] wd, exp_rd;
        int          idx, lat, prev_acc, prev_lat, bad;
        exp_t        e;
        for (int i = 0; i < 64; i++) mdl[i] = mem[i];
        prev_acc = 0; prev_lat = 0;
        for (int i = 0; i < 16; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 2));
            sg  = 1'($urandom_range(0, 1));
            idx = 8 + $urandom_range(0, 7);
            off = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            wd  = $urandom;
            if (we) begin
                exp_rd = 32'h0;
                lat = (sz == 2'b10) ? 2 : 3;
                mdl[idx] = m_store(mdl[idx], sz, off, wd);
            end else begin
                exp_rd = m_load(mdl[idx], sz, sg, off);
                lat = 2;
            end
            run_req(we, sz, sg, (idx * 4) + off, wd, exp_rd, 1'b0, lat);
            e = sb.pop_front();
            tests++;
            if (got_rdata !== e.rdata || got_err !== e.err || got_lat != e.lat ||
                (i > 0 && accept_cyc - prev_acc != prev_lat + 1)) begin
                failed++;
                $display("FAIL b2b_%0d got %h/%b/lat%0d gap%0d want %h/%b/lat%0d gap%0d", i, got_rdata, got_err,
                         got_lat, accept_cyc - prev_acc, e.rdata, e.err, e.lat, prev_lat + 1);
            end
            prev_acc = accept_cyc;
            prev_lat = lat;
        end
        bad = 0;
        for (int i = 8; i < 16; i++) if (mem[i] !== mdl[i]) bad++;
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL b2b_mem got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_word();
        test_byte_store();
        test_extend();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
